x_in_to_single_out: RTL and testbench

X_IN_TO_SINGLE_OUT -- requirements
Module: x_in_to_single_out

---
 rtl/x_in_to_single_out.sv | 121 ++++++++++++
 tb/tb_x_in_to_single_out.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/x_in_to_single_out.sv
// Parallel-to-serial converter: accepts an NUM_INS-bit word and emits it LSB first, one bit per clk.
// Optional even-parity trailer bit is enabled by defining X_IN_TO_SINGLE_OUT_PARITY_EN.
//
// state  | meaning
// IDLE   | no frame in flight, ready for a word
// SHIFT  | out carries data bit r_cnt of the captured word
// PARITY | out carries the even-parity bit (X_IN_TO_SINGLE_OUT_PARITY_EN only)
module x_in_to_single_out #(
    parameter int NUM_INS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INS-1:0] i_in_data,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic               o_out,
    output logic               o_out_valid,
    output logic               o_out_last
);

    localparam int CW = $clog2(NUM_INS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_INS - 1);

`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             r_state;
    logic [NUM_INS-1:0] r_shift;
    logic [CW-1:0]      r_cnt;
    logic               r_out;
    logic               r_out_valid;
    logic               r_out_last;
`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
    logic               r_parity;
`endif

    logic          w_final;
    logic          w_ready;
    logic          w_xfer;
    logic [CW-1:0] w_cnt_nxt;

    // The final frame cycle is the last data bit, or the parity bit when enabled.
`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
    assign w_final = (r_state == PARITY);
`else
    assign w_final = (r_state == SHIFT) && (r_cnt == LAST_CNT);
`endif

    assign w_ready   = !rst && ((r_state == IDLE) || w_final);
    assign w_xfer    = i_in_valid && w_ready;
    assign w_cnt_nxt = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_state     <= SHIFT;
            r_shift     <= i_in_data;
            r_cnt       <= '0;
            r_out       <= i_in_data[0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
            r_parity    <= ^i_in_data;
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    if (r_cnt != LAST_CNT) begin
                        r_cnt       <= w_cnt_nxt;
                        r_shift     <= r_shift >> 1;
                        r_out       <= r_shift[1];
                        r_out_valid <= 1'b1;
`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
                        r_out_last  <= 1'b0;
`else
                        r_out_last  <= (w_cnt_nxt == LAST_CNT);
`endif
                    end else begin
`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
                        r_state     <= PARITY;
                        r_out       <= r_parity;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
`else
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = w_ready;
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_x_in_to_single_out.sv
// Bench for x_in_to_single_out: directed and random words against a queue-based frame model.
// Expectations follow X_IN_TO_SINGLE_OUT_PARITY_EN when it is defined for the build.
module tb_x_in_to_single_out;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d8;
    logic       v8;
    logic [1:0] d2;
    logic       v2;
    logic       rdy8, out8, ov8, ol8;
    logic       rdy2, out2, ov2, ol2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic b;
        logic l;
    } ent_t;

    // One entry per future output cycle; the head is what out shows this cycle.
    ent_t q[$];

`ifdef X_IN_TO_SINGLE_OUT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    always #5 clk = ~clk;

    x_in_to_single_out #(.NUM_INS(8)) u_dut8 (
        .clk(clk), .rst(rst), .i_in_data(d8), .i_in_valid(v8),
        .o_in_ready(rdy8), .o_out(out8), .o_out_valid(ov8), .o_out_last(ol8)
    );

    x_in_to_single_out #(.NUM_INS(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_in_data(d2), .i_in_valid(v2),
        .o_in_ready(rdy2), .o_out(out2), .o_out_valid(ov2), .o_out_last(ol2)
    );

    task automatic chk(input string tag, input logic act, input logic exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s at t=%0t: got %b expected %b", tag, $time, act, exp);
    endtask

    task automatic push_frame(input logic [7:0] d, input int n);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e.b = d[k];
            e.l = (k == n - 1) && !PAR;
            q.push_back(e);
        end
        if (PAR) begin
            e.b = 1'b0;
            for (int k = 0; k < n; k++) e.b = e.b ^ d[k];
            e.l = 1'b1;
            q.push_back(e);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance the model at posedge.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input bit sel2);
        logic a_rdy, a_out, a_val, a_last;
        bit   exp_rdy, xfer;
        rst = r;
        if (sel2) begin
            v2 = v; d2 = d[1:0]; v8 = 1'b0;
        end else begin
            v8 = v; d8 = d; v2 = 1'b0;
        end
        #1;
        if (sel2) {a_rdy, a_out, a_val, a_last} = {rdy2, out2, ov2, ol2};
        else      {a_rdy, a_out, a_val, a_last} = {rdy8, out8, ov8, ol8};
        exp_rdy = !r && (q.size() <= 1);
        chk(sel2 ? "ready2" : "ready8", a_rdy, exp_rdy);
        chk(sel2 ? "valid2" : "valid8", a_val, q.size() > 0);
        chk(sel2 ? "out2"   : "out8",   a_out, (q.size() > 0) ? q[0].b : 1'b0);
        chk(sel2 ? "last2"  : "last8",  a_last, (q.size() > 0) ? q[0].l : 1'b0);
        xfer = v && exp_rdy;
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (q.size() > 0) void'(q.pop_front());
            if (xfer) push_frame(d, sel2 ? 2 : 8);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] words[3];
        logic [7:0] w2[2];
        bit         rd;
        rst = 1'b1; v8 = 1'b0; d8 = '0; v2 = 1'b0; d2 = '0;
        @(posedge clk);
        @(negedge clk);
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h55, 0);

        step(0, 1, 8'hA5, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 8'hA5, 0);

        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        for (int i = 0; i < 3; ) begin
            rd = (q.size() <= 1);
            step(0, 1, words[i], 0);
            if (rd) i++;
        end
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 0);

        step(0, 1, 8'h3C, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h3C, 0);
        step(1, 0, 8'h3C, 0);
        step(0, 1, 8'h0F, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 8'h0F, 0);

        step(0, 1, 8'hC3, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 0);

        step(0, 1, 8'h07, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 8'h07, 0);
        step(0, 1, 8'h03, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 8'h03, 0);

        w2[0] = 8'h02; w2[1] = 8'h01;
        for (int i = 0; i < 2; ) begin
            rd = (q.size() <= 1);
            step(0, 1, w2[i], 1);
            if (rd) i++;
        end
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 8'($urandom), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 0);
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 8'($urandom), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
